fifo_burst_rd_ctrl: RTL and testbench
=====================================

// Module: fifo_burst_rd_ctrl
// PURPOSE
//  Read-side scheduler for the asynchronous pixel FIFO in the scaling datapath, running in the rd_clk domain.
//  Waits until the FIFO holds a full burst, then drains it with back-to-back rd_en pulses.
//  Tags each pixel with start-of-line/end-of-line and inserts a fixed idle gap between lines.
//  Output is a registered valid/ready stream that feeds the bilinear interpolation pipeline.
// PARAMETERS
//  C_DATA_WIDTH        8    pixel width; equals the FIFO data width
//  C_FIFO_DEPTH_WIDTH  4    FIFO address width; rd_cnt is C_FIFO_DEPTH_WIDTH+1 bits
//  C_BURST_LEN         8    pixels per burst; 1..2**C_FIFO_DEPTH_WIDTH
//  C_LINE_PIXELS       640  pixels per line; >=1
//  C_PIX_CNT_WIDTH     12   width of the pixel counter; 2**C_PIX_CNT_WIDTH > C_LINE_PIXELS
//  C_GAP_CYCLES        4    idle cycles after each line; 0 means no gap
// PORTS
//  clk            in   1                      read-domain clock; the FIFO rd_clk
//  rst_n          in   1                      asynchronous reset, active low
//  enable         in   1                      level; allows new bursts to start
//  fifo_rd_en     out  1                      FIFO read strobe
//  fifo_rd_data   in   C_DATA_WIDTH           FIFO read data; combinational from the current rd_addr
//  fifo_rd_empty  in   1                      FIFO registered empty flag
//  fifo_rd_cnt    in   C_FIFO_DEPTH_WIDTH+1   FIFO registered fill count
//  dout           out  C_DATA_WIDTH           pixel to downstream
//  dout_valid     out  1                      dout is valid
//  dout_ready     in   1                      downstream accepts dout
//  dout_sol       out  1                      first pixel of line; qualified by dout_valid
//  dout_eol       out  1                      last pixel of line; qualified by dout_valid
//  line_done      out  1                      one-cycle pulse when the eol pixel is accepted
//  busy           out  1                      state is not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; pix_cnt=0; burst_cnt=0; gap_cnt=0.
//    All outputs are 0, including dout.
//  burst_len = min(C_BURST_LEN, C_LINE_PIXELS - pix_cnt); the last burst of a line is short.
//  States:
//    IDLE  -> WAIT when enable=1.
//    WAIT  -> BURST when fifo_rd_cnt >= burst_len.
//             -> IDLE when enable=0.
//             burst_cnt is loaded with burst_len on the WAIT->BURST transition.
//    BURST -> GAP when the eol pixel is read and C_GAP_CYCLES>0.
//             -> WAIT when the eol pixel is read and C_GAP_CYCLES=0.
//             -> WAIT when burst_cnt reaches 0 and the line is not finished.
//    GAP   -> WAIT after C_GAP_CYCLES cycles; gap_cnt counts down.
//  Read strobe: fifo_rd_en = (state==BURST) & ~fifo_rd_empty & (~dout_valid | dout_ready).
//    No read is issued outside BURST or when the FIFO is empty.
//  Output register: on a cycle with fifo_rd_en=1, the next cycle has:
//    dout=fifo_rd_data; dout_valid=1;
//    dout_sol=(pix_cnt==0); dout_eol=(pix_cnt==C_LINE_PIXELS-1).
//  Latency: 1 cycle from fifo_rd_en to dout_valid.
//  Hold rule: dout_valid stays 1 and dout, dout_sol, dout_eol stay stable until dout_ready=1.
//  Read and accept in the same cycle: the register is reloaded and no bubble is inserted.
//  Accept without a read: dout_valid=0 the next cycle.
//  Each read increments pix_cnt and decrements burst_cnt; pix_cnt wraps to 0 after C_LINE_PIXELS-1.
//  line_done pulses for one cycle on the cycle the eol pixel is accepted (dout_valid & dout_ready & dout_eol).
//  enable=0 during BURST or GAP: the current burst, or gap, completes, then WAIT moves to IDLE.
//    Bursts are never truncated. pix_cnt is kept, so the line resumes when enable returns to 1.
//  A pending output word is always drained, whatever the state of enable.
//  Async reset mid-burst: immediate return to IDLE, dout_valid drops to 0, and the partial line is discarded.
//    The FIFO is reset from the same source.
//  fifo_rd_cnt lags FIFO writes, never this block's own reads.
//    The threshold test is therefore safe, and the empty gate is a second guard.
// TESTING
//  Fill FIFO with 8 pixels 0x10..0x17, enable=1, dout_ready=1:
//    -> 8 consecutive fifo_rd_en; dout 0x10..0x17 on cycles 1..8 after the first read.
//  Hold fifo_rd_cnt at 7, C_BURST_LEN=8 -> no fifo_rd_en.
//    Write 1 more pixel -> burst starts once fifo_rd_cnt=8.
//  C_LINE_PIXELS=20, C_BURST_LEN=8 -> bursts of 8, 8 and 4.
//    sol on pixel 0, eol on pixel 19; line_done one cycle; then 4 GAP cycles with no read.
//  Toggle dout_ready 1,0,0,1 during a burst -> no read while a word is held.
//    dout is stable while ready=0; no pixel is lost or duplicated.
//  Drop enable mid-burst -> the remaining burst pixels are still read, then IDLE, busy=0.
//    Raise enable -> pix_cnt continues from where it stopped.
//  Assert rst_n=0 mid-burst -> all outputs 0 immediately.
//    After release and refill, the first pixel carries dout_sol=1.

Source files
------------

// File: rtl/fifo_burst_rd_ctrl.sv
// Purpose : read-side burst scheduler for the async pixel FIFO; waits for a full burst,
//           drains it with back-to-back reads, tags sol/eol and inserts an idle gap per line.
// Latency : 1 cycle from fifo_rd_en to dout_valid; registered output word.
// Backpressure: dout_valid/dout_ready; no read is issued while an output word is held.
// Ports: clk/rst_n (rd_clk domain, async active-low reset), enable (level, gates new bursts),
//        fifo_rd_en/fifo_rd_data/fifo_rd_empty/fifo_rd_cnt (FIFO read side),
//        dout/dout_valid/dout_ready/dout_sol/dout_eol (pixel stream), line_done, busy.
module fifo_burst_rd_ctrl #(
  parameter int C_DATA_WIDTH       = 8,
  parameter int C_FIFO_DEPTH_WIDTH = 4,
  parameter int C_BURST_LEN        = 8,
  parameter int C_LINE_PIXELS      = 640,
  parameter int C_PIX_CNT_WIDTH    = 12,
  parameter int C_GAP_CYCLES       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic                          fifo_rd_en,
  input  logic [C_DATA_WIDTH-1:0]       fifo_rd_data,
  input  logic                          fifo_rd_empty,
  input  logic [C_FIFO_DEPTH_WIDTH:0]   fifo_rd_cnt,
  output logic [C_DATA_WIDTH-1:0]       dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_sol,
  output logic                          dout_eol,
  output logic                          line_done,
  output logic                          busy
);

  localparam int PW     = C_PIX_CNT_WIDTH;
  // common width for comparing the fill count against the burst length
  localparam int CW     = (PW + 1 > C_FIFO_DEPTH_WIDTH + 1) ? PW + 1 : C_FIFO_DEPTH_WIDTH + 1;
  localparam int BCW    = $clog2(C_BURST_LEN + 1);
  localparam int GW     = (C_GAP_CYCLES > 0) ? $clog2(C_GAP_CYCLES + 1) : 1;
  localparam int LAST_I = C_LINE_PIXELS - 1;

  localparam logic [PW-1:0] LAST_PIX  = LAST_I[PW-1:0];
  localparam logic [CW-1:0] LINE_PIX  = C_LINE_PIXELS[CW-1:0];
  localparam logic [CW-1:0] BURST_MAX = C_BURST_LEN[CW-1:0];
  localparam logic [GW-1:0] GAP_LOAD  = C_GAP_CYCLES[GW-1:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST, ST_GAP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pix_cnt;
  logic [BCW-1:0]  burst_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   remain, burst_len, fill;
  logic            rd, last_pix, start_burst, enter_gap;

  // the last burst of a line is shortened to the pixels left in that line
  always_comb begin
    remain    = LINE_PIX - CW'(pix_cnt);
    burst_len = (remain < BURST_MAX) ? remain : BURST_MAX;
    fill      = CW'(fifo_rd_cnt);
  end

  // a read only happens when the output register is free or being emptied this cycle
  assign rd          = (state == ST_BURST) & ~fifo_rd_empty & (~dout_valid | dout_ready);
  assign last_pix    = (pix_cnt == LAST_PIX);
  assign fifo_rd_en  = rd;
  assign busy        = (state != ST_IDLE);
  assign line_done   = dout_valid & dout_ready & dout_eol;
  assign start_burst = (state == ST_WAIT) & (state_nxt == ST_BURST);
  assign enter_gap   = (state != ST_GAP) & (state_nxt == ST_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // enable is only looked at in IDLE/WAIT, so bursts and gaps always run to completion
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable)                 state_nxt = ST_IDLE;
        else if (fill >= burst_len)  state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (rd && last_pix) begin
          if (C_GAP_CYCLES > 0) state_nxt = ST_GAP;
          else                  state_nxt = ST_WAIT;
        end else if (rd && (burst_cnt == BCW'(1))) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sol   <= 1'b0;
      dout_eol   <= 1'b0;
    end else begin
      if (start_burst)  burst_cnt <= BCW'(burst_len);
      else if (rd)      burst_cnt <= burst_cnt - 1'b1;

      if (rd) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;

      if (enter_gap)             gap_cnt <= GAP_LOAD;
      else if (state == ST_GAP)  gap_cnt <= gap_cnt - 1'b1;

      // reload on read (covers read+accept with no bubble); drop valid on accept alone
      if (rd) begin
        dout       <= fifo_rd_data;
        dout_valid <= 1'b1;
        dout_sol   <= (pix_cnt == '0);
        dout_eol   <= last_pix;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Purpose : directed bench for fifo_burst_rd_ctrl with a behavioural FIFO and pixel scoreboard.
// Latency : expects dout one cycle after each read, gap of 4 idle cycles after each 20-pixel line.
// Backpressure: toggles dout_ready and checks that held words stay stable and no read occurs.
module tb_fifo_burst_rd_ctrl;

  localparam int LP = 20;

  typedef struct packed {
    logic       sol;
    logic       eol;
    logic [7:0] d;
  } px_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       dout_ready = 1'b0;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = '0;
  logic       fifo_rd_empty = 1'b1;
  logic [4:0] fifo_rd_cnt = '0;
  logic [7:0] dout;
  logic       dout_valid, dout_sol, dout_eol, line_done, busy;

  fifo_burst_rd_ctrl #(
    .C_DATA_WIDTH(8), .C_FIFO_DEPTH_WIDTH(4), .C_BURST_LEN(8),
    .C_LINE_PIXELS(LP), .C_PIX_CNT_WIDTH(12), .C_GAP_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_cnt(fifo_rd_cnt),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sol(dout_sol), .dout_eol(dout_eol),
    .line_done(line_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errs = 0;
  int   cyc = 0;
  int   rd_count = 0;
  int   done_count = 0;
  int   first_rd_cyc = -1;
  int   first_val_cyc = -1;
  int   last_rd_cyc = -1;
  int   line_pos = 0;
  logic pop_flag = 1'b0;
  logic hold = 1'b0;
  logic [9:0] hold_word = '0;

  logic [7:0] fq[$];
  logic [7:0] wq[$];
  px_t        exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // behavioural FIFO: registered flags, reads seen immediately, writes one edge late
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      wq.delete();
    end else begin
      if (pop_flag && fq.size() > 0) void'(fq.pop_front());
      while (wq.size() > 0) fq.push_back(wq.pop_front());
    end
    fifo_rd_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
    fifo_rd_empty <= (fq.size() == 0);
    fifo_rd_cnt   <= 5'(fq.size());
  end

  // output monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    px_t e;
    cyc++;
    if (!rst_n) begin
      pop_flag = 1'b0;
      hold = 1'b0;
    end else begin
      pop_flag = fifo_rd_en;
      if (fifo_rd_en) begin
        rd_count++;
        last_rd_cyc = cyc;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (dout_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (hold) begin
        chk("hold_word", {dout_sol, dout_eol, dout}, hold_word);
        chk("hold_valid", dout_valid, 1'b1);
      end
      if (dout_valid && !dout_ready) chk("no_rd_while_held", fifo_rd_en, 1'b0);
      if (dout_valid && dout_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pix_data", dout, e.d);
          chk("pix_sol", dout_sol, e.sol);
          chk("pix_eol", dout_eol, e.eol);
        end
        chk("line_done", line_done, dout_eol);
        if (line_done) done_count++;
      end else begin
        chk("line_done_quiet", line_done, 1'b0);
      end
      hold = dout_valid && !dout_ready;
      hold_word = {dout_sol, dout_eol, dout};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input logic [7:0] d);
    px_t e;
    e.sol = (line_pos == 0);
    e.eol = (line_pos == LP - 1);
    e.d   = d;
    wq.push_back(d);
    exp_q.push_back(e);
    line_pos = (line_pos == LP - 1) ? 0 : line_pos + 1;
  endtask

  task automatic wait_reads(input int target, input string tag);
    int n = 0;
    while (rd_count < target && n < 200) begin
      step();
      n++;
    end
    chk(tag, rd_count, target);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 8'h00);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_sol"}, dout_sol, 1'b0);
    chk({tag, "_eol"}, dout_eol, 1'b0);
    chk({tag, "_line_done"}, line_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
  endtask

  initial begin
    int eol_cyc;
    int n;

    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // full burst of 0x10..0x17, streaming output
    dout_ready = 1'b1;
    rd_count = 0; first_rd_cyc = -1; first_val_cyc = -1;
    for (int i = 0; i < 8; i++) push_pix(8'(8'h10 + i));
    enable = 1'b1;
    wait_reads(8, "t1_reads");
    repeat (3) step();
    chk("t1_back_to_back", last_rd_cyc - first_rd_cyc, 7);
    chk("t1_latency", first_val_cyc - first_rd_cyc, 1);
    chk("t1_drained", exp_q.size(), 0);

    // seven pixels are below the burst threshold; the eighth starts the burst
    rd_count = 0;
    for (int i = 0; i < 7; i++) push_pix(8'(8'h20 + i));
    repeat (10) step();
    chk("t2_no_read_at_7", rd_count, 0);
    chk("t2_busy_waiting", busy, 1'b1);
    push_pix(8'h27);
    wait_reads(8, "t2_reads");

    // short 4-pixel end of line, then gap, then next line with ready toggling
    rd_count = 0; done_count = 0;
    for (int i = 0; i < 4; i++) push_pix(8'(8'h30 + i));
    for (int i = 0; i < 8; i++) push_pix(8'(8'h40 + i));
    wait_reads(4, "t3_short_burst");
    eol_cyc = last_rd_cyc;
    wait_reads(5, "t3_next_line_start");
    chk("t3_gap_spacing", last_rd_cyc - eol_cyc, 6);
    step();
    dout_ready = 1'b0;
    step();
    step();
    dout_ready = 1'b1;
    wait_reads(12, "t4_reads_with_stall");
    repeat (3) step();
    chk("t3_line_done_once", done_count, 1);

    // drop enable mid-burst: burst completes, block idles, line resumes later
    rd_count = 0;
    for (int i = 0; i < 8; i++) push_pix(8'(8'h50 + i));
    wait_reads(3, "t5_burst_started");
    enable = 1'b0;
    wait_reads(8, "t5_burst_completes");
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk("t5_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) push_pix(8'(8'h60 + i));
    repeat (8) step();
    chk("t5_no_read_disabled", rd_count, 8);
    enable = 1'b1;
    wait_reads(12, "t5_resume");
    repeat (3) step();
    chk("t5_line_done_total", done_count, 2);
    chk("t5_drained", exp_q.size(), 0);

    // reset in the middle of a burst
    rd_count = 0;
    for (int i = 0; i < 8; i++) push_pix(8'(8'h70 + i));
    wait_reads(3, "t6_burst_started");
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_mid_reset");
    exp_q.delete();
    line_pos = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    rd_count = 0;
    for (int i = 0; i < 8; i++) push_pix(8'(8'h80 + i));
    n = 0;
    while (!dout_valid && n < 50) begin
      step();
      n++;
    end
    chk("t6_first_valid", dout_valid, 1'b1);
    chk("t6_first_sol", dout_sol, 1'b1);
    chk("t6_first_data", dout, 8'h80);
    wait_reads(8, "t6_reads");
    repeat (5) step();
    chk("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
